// File: rtl/showcase_ram_arbiter.sv
// Round-robin arbiter that serialises REQ_CNT requesters onto one small register-file RAM
// and returns one tagged response per transaction.
module showcase_ram_arbiter #(
    parameter int REQ_CNT    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    localparam int ID_WIDTH  = $clog2(REQ_CNT)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [REQ_CNT-1:0]             req_vld,
    input  logic [REQ_CNT-1:0]             req_wr,
    input  logic [REQ_CNT*ADDR_WIDTH-1:0]  req_addr,
    input  logic [REQ_CNT*DATA_WIDTH-1:0]  req_wdata,
    output logic [REQ_CNT-1:0]             req_rdy,
    output logic                           resp_vld,
    input  logic                           resp_rdy,
    output logic [ID_WIDTH-1:0]            resp_id,
    output logic                           resp_wr,
    output logic [DATA_WIDTH-1:0]          resp_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]            state;
    logic [ID_WIDTH-1:0]   last;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  grant_found;
    int                    scan_idx;

    logic                  op_wr;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [ID_WIDTH-1:0]   op_id;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Scan starts just after the previous winner so a persistent requester waits at most REQ_CNT turns.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        for (int i = 1; i <= REQ_CNT; i++) begin
            scan_idx = (int'(last) + i) % REQ_CNT;
            if (!grant_found && req_vld[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_WIDTH'(scan_idx);
            end
        end
    end

    // Gating with rst_n keeps a handshake from being accepted while reset is asserted.
    assign req_rdy = (rst_n && state == IDLE && grant_found) ?
                     (REQ_CNT'(1) << grant_id) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= ID_WIDTH'(REQ_CNT - 1);
            resp_vld  <= 1'b0;
            resp_id   <= '0;
            resp_wr   <= 1'b0;
            resp_data <= '0;
            op_wr     <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= '0;
            op_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_wr    <= req_wr[grant_id];
                        op_addr  <= req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
                        op_wdata <= req_wdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                        op_id    <= grant_id;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    resp_vld  <= 1'b1;
                    resp_id   <= op_id;
                    resp_wr   <= op_wr;
                    resp_data <= op_wr ? '0 : mem[op_addr];
                    state     <= RESP;
                end
                RESP: begin
                    if (resp_rdy) begin
                        resp_vld <= 1'b0;
                        last     <= op_id;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM contents are deliberately not reset so they survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && state == ACCESS && op_wr) begin
            mem[op_addr] <= op_wdata;
        end
    end

endmodule

// File: tb/tb_showcase_ram_arbiter.sv
// Self-checking bench for showcase_ram_arbiter: directed scenarios plus randomized
// back-to-back traffic compared against a round-robin/array reference model.
module tb_showcase_ram_arbiter;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int AW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_vld;
    logic [N-1:0]    req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_rdy;
    logic            resp_vld;
    logic            resp_rdy;
    logic [0:0]      resp_id;
    logic            resp_wr;
    logic [DW-1:0]   resp_data;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [DW-1:0] model_mem [4];
    bit            model_written [4];
    int            model_last;

    showcase_ram_arbiter #(.REQ_CNT(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vld   (req_vld),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rdy   (req_rdy),
        .resp_vld  (resp_vld),
        .resp_rdy  (resp_rdy),
        .resp_id   (resp_id),
        .resp_wr   (resp_wr),
        .resp_data (resp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected summary before it");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requesting index after the previous winner, wrapping.
    function automatic int model_pick(input logic [N-1:0] vld);
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (model_last + i) % N;
            if (vld[k]) return k;
        end
        return -1;
    endfunction

    // Drives one isolated transaction and reports what was observed; callers do the checking.
    task automatic do_txn(input int who, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, output int g, output int lat,
                          output logic rwr, output int rid, output logic [DW-1:0] rdata,
                          output bit ok);
        int w;
        ok = 1'b0; g = -1; lat = -1; rwr = 1'b0; rid = -1; rdata = '0;
        req_wr[who] = wr;
        req_addr[who*AW +: AW] = addr;
        req_wdata[who*DW +: DW] = data;
        req_vld[who] = 1'b1;
        resp_rdy = 1'b1;
        #1;
        w = 0;
        while (req_rdy == '0 && w < 20) begin tick(); w++; end
        if (req_rdy == '0) begin req_vld = '0; return; end
        g = (req_rdy == 2'b01) ? 0 : (req_rdy == 2'b10) ? 1 : -2;
        lat = 0;
        while (!resp_vld && lat < 20) begin tick(); lat++; end
        req_vld[who] = 1'b0;
        if (!resp_vld) return;
        rwr = resp_wr; rid = int'(resp_id); rdata = resp_data; ok = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_vld = '0; req_wr = '0; req_addr = '0; req_wdata = '0; resp_rdy = 1'b1;
        tick(); tick();
        model_last = N - 1;
        n_cmp++; if (resp_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_vld: got %0b expected 0", resp_vld); end
        n_cmp++; if (resp_id !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_id: got %0d expected 0", resp_id); end
        n_cmp++; if (resp_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_wr: got %0b expected 0", resp_wr); end
        n_cmp++; if (resp_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_resp_data: got %0h expected 00", resp_data); end
        n_cmp++; if (req_rdy !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_req_rdy: got %0b expected 00", req_rdy); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if ({resp_vld, req_rdy} !== 3'b000) begin n_fail++; $display("[TB] FAIL idle_no_req: got %0b expected 000", {resp_vld, req_rdy}); end
    endtask

    task automatic test_write();
        int g, lat, rid; logic rwr; logic [DW-1:0] rdata; bit ok; int g_exp;
        g_exp = model_pick(2'b01);
        do_txn(0, 1'b1, 2'd2, 8'hA5, g, lat, rwr, rid, rdata, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL write_done: got %0b expected 1", ok); end
        n_cmp++; if (g !== g_exp) begin n_fail++; $display("[TB] FAIL write_grant: got %0d expected %0d", g, g_exp); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL write_latency: got %0d expected 2", lat); end
        n_cmp++; if ({rwr, rid[0], rdata} !== {1'b1, 1'b0, 8'h00}) begin n_fail++; $display("[TB] FAIL write_resp: got wr=%0b id=%0d data=%0h expected wr=1 id=0 data=00", rwr, rid, rdata); end
        model_mem[2] = 8'hA5; model_written[2] = 1'b1; model_last = 0;
    endtask

    task automatic test_read();
        int g, lat, rid; logic rwr; logic [DW-1:0] rdata; bit ok; int g_exp;
        g_exp = model_pick(2'b10);
        do_txn(1, 1'b0, 2'd2, 8'h00, g, lat, rwr, rid, rdata, ok);
        n_cmp++; if (g !== g_exp) begin n_fail++; $display("[TB] FAIL read_grant: got %0d expected %0d", g, g_exp); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL read_latency: got %0d expected 2", lat); end
        n_cmp++; if ({rwr, rid[0]} !== {1'b0, 1'b1} || rid !== 1) begin n_fail++; $display("[TB] FAIL read_tag: got wr=%0b id=%0d expected wr=0 id=1", rwr, rid); end
        n_cmp++; if (rdata !== model_mem[2]) begin n_fail++; $display("[TB] FAIL read_data: got %0h expected %0h", rdata, model_mem[2]); end
        model_last = 1;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] f_wr; logic [AW-1:0] f_addr [N]; logic [DW-1:0] f_data [N];
        int g, g_exp, lat, w, prev_cyc; logic [DW-1:0] exp_data;
        rst_n = 1'b0; tick(); rst_n = 1'b1; model_last = N - 1;
        prev_cyc = 0;
        for (int k = 0; k < N; k++) begin
            f_addr[k] = AW'($urandom_range(0, 3));
            f_wr[k]   = model_written[f_addr[k]] ? 1'($urandom_range(0, 1)) : 1'b1;
            f_data[k] = DW'($urandom);
            req_wr[k] = f_wr[k]; req_addr[k*AW +: AW] = f_addr[k]; req_wdata[k*DW +: DW] = f_data[k];
        end
        req_vld = 2'b11; resp_rdy = 1'b1;
        #1;
        for (int t = 0; t < 8; t++) begin
            w = 0;
            while (req_rdy == '0 && w < 10) begin tick(); w++; end
            g = (req_rdy == 2'b01) ? 0 : (req_rdy == 2'b10) ? 1 : -1;
            g_exp = model_pick(2'b11);
            n_cmp++; if (g !== g_exp) begin n_fail++; $display("[TB] FAIL b2b_grant[%0d]: got %0d expected %0d", t, g, g_exp); end
            if (g < 0) break;
            if (t > 0) begin
                n_cmp++; if (cyc - prev_cyc !== 3) begin n_fail++; $display("[TB] FAIL b2b_interval[%0d]: got %0d expected 3", t, cyc - prev_cyc); end
            end
            prev_cyc = cyc;
            exp_data = f_wr[g] ? 8'h00 : model_mem[f_addr[g]];
            lat = 0;
            while (!resp_vld && lat < 10) begin tick(); lat++; end
            n_cmp++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected 2", t, lat); end
            n_cmp++; if ({resp_id, resp_wr, resp_data} !== {1'(g), f_wr[g], exp_data}) begin n_fail++; $display("[TB] FAIL b2b_resp[%0d]: got id=%0d wr=%0b data=%0h expected id=%0d wr=%0b data=%0h", t, resp_id, resp_wr, resp_data, g, f_wr[g], exp_data); end
            if (f_wr[g]) begin model_mem[f_addr[g]] = f_data[g]; model_written[f_addr[g]] = 1'b1; end
            model_last = g;
            f_addr[g] = AW'($urandom_range(0, 3));
            f_wr[g]   = model_written[f_addr[g]] ? 1'($urandom_range(0, 1)) : 1'b1;
            f_data[g] = DW'($urandom);
            req_wr[g] = f_wr[g]; req_addr[g*AW +: AW] = f_addr[g]; req_wdata[g*DW +: DW] = f_data[g];
            tick();
        end
        req_vld = '0;
        // Flush any transaction already handed to the arbiter by the final grant window.
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_stall();
        int w, lat; logic [DW-1:0] exp_data; logic [N-1:0] exp_rdy;
        exp_rdy = N'(1) << model_pick(2'b01);
        req_wr[0] = 1'b0; req_addr[1:0] = 2'd2; resp_rdy = 1'b0; req_vld = 2'b01;
        #1;
        w = 0;
        while (req_rdy == '0 && w < 10) begin tick(); w++; end
        n_cmp++; if (req_rdy !== exp_rdy) begin n_fail++; $display("[TB] FAIL stall_grant: got %0b expected %0b", req_rdy, exp_rdy); end
        exp_data = model_mem[2];
        lat = 0;
        while (!resp_vld && lat < 10) begin tick(); lat++; end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL stall_latency: got %0d expected 2", lat); end
        req_vld = 2'b10; req_wr[1] = 1'b1; req_addr[3:2] = 2'd1; req_wdata[15:8] = 8'h5A;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if ({resp_vld, resp_id, resp_wr, resp_data, req_rdy} !== {1'b1, 1'b0, 1'b0, exp_data, 2'b00}) begin n_fail++; $display("[TB] FAIL stall_hold[%0d]: got vld=%0b id=%0d wr=%0b data=%0h rdy=%0b expected vld=1 id=0 wr=0 data=%0h rdy=00", c, resp_vld, resp_id, resp_wr, resp_data, req_rdy, exp_data); end
        end
        req_vld = '0; resp_rdy = 1'b1;
        tick();
        n_cmp++; if (resp_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_release: got %0b expected 0", resp_vld); end
        model_last = 0;
    endtask

    task automatic test_wrap();
        int g, lat, rid; logic rwr; logic [DW-1:0] rdata, v0; bit ok;
        v0 = DW'($urandom);
        do_txn(0, 1'b1, 2'd0, v0, g, lat, rwr, rid, rdata, ok);
        n_cmp++; if (ok !== 1'b1 || rwr !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_write0: got ok=%0b wr=%0b expected ok=1 wr=1", ok, rwr); end
        model_mem[0] = v0; model_written[0] = 1'b1; model_last = 0;
        do_txn(1, 1'b1, 2'd3, 8'h3C, g, lat, rwr, rid, rdata, ok);
        n_cmp++; if (ok !== 1'b1 || rid !== 1) begin n_fail++; $display("[TB] FAIL wrap_write3: got ok=%0b id=%0d expected ok=1 id=1", ok, rid); end
        model_mem[3] = 8'h3C; model_written[3] = 1'b1; model_last = 1;
        do_txn(0, 1'b0, 2'd0, 8'h00, g, lat, rwr, rid, rdata, ok);
        n_cmp++; if (rdata !== model_mem[0]) begin n_fail++; $display("[TB] FAIL wrap_read0: got %0h expected %0h", rdata, model_mem[0]); end
        model_last = 0;
        do_txn(1, 1'b0, 2'd3, 8'h00, g, lat, rwr, rid, rdata, ok);
        n_cmp++; if (rdata !== model_mem[3]) begin n_fail++; $display("[TB] FAIL wrap_read3: got %0h expected %0h", rdata, model_mem[3]); end
        model_last = 1;
    endtask

    task automatic test_reset_mid();
        int g, lat, rid, w; logic rwr; logic [DW-1:0] rdata, v1, v2; bit ok; logic [N-1:0] exp_rdy;
        v1 = DW'($urandom); v2 = DW'($urandom);
        do_txn(0, 1'b1, 2'd1, v1, g, lat, rwr, rid, rdata, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_setup: got %0b expected 1", ok); end
        model_mem[1] = v1; model_written[1] = 1'b1; model_last = 0;
        req_wr[0] = 1'b1; req_addr[1:0] = 2'd2; req_wdata[7:0] = v2; resp_rdy = 1'b0; req_vld = 2'b01;
        #1;
        w = 0;
        while (req_rdy == '0 && w < 10) begin tick(); w++; end
        lat = 0;
        while (!resp_vld && lat < 10) begin tick(); lat++; end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL rstmid_in_resp: got latency %0d expected 2", lat); end
        req_vld = '0; rst_n = 1'b0;
        tick();
        n_cmp++; if ({resp_vld, req_rdy} !== 3'b000) begin n_fail++; $display("[TB] FAIL rstmid_drop: got vld=%0b rdy=%0b expected vld=0 rdy=00", resp_vld, req_rdy); end
        rst_n = 1'b1; resp_rdy = 1'b1; model_last = N - 1;
        model_mem[2] = v2; model_written[2] = 1'b1;
        tick();
        n_cmp++; if (resp_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_no_resp: got %0b expected 0", resp_vld); end
        req_wr = 2'b00; req_addr[1:0] = 2'd2; req_addr[3:2] = 2'd1; req_vld = 2'b11;
        #1;
        exp_rdy = N'(1) << model_pick(2'b11);
        n_cmp++; if (req_rdy !== exp_rdy) begin n_fail++; $display("[TB] FAIL rstmid_regrant: got %0b expected %0b", req_rdy, exp_rdy); end
        lat = 0;
        while (!resp_vld && lat < 10) begin tick(); lat++; end
        n_cmp++; if ({resp_id, resp_data} !== {1'b0, model_mem[2]}) begin n_fail++; $display("[TB] FAIL rstmid_write_kept: got id=%0d data=%0h expected id=0 data=%0h", resp_id, resp_data, model_mem[2]); end
        req_vld = '0;
        tick();
        model_last = 0;
    endtask

    initial begin
        for (int a = 0; a < 4; a++) begin model_mem[a] = '0; model_written[a] = 1'b0; end
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
